spec_tag_mgr: RTL and testbench

- Producer of the speculation-tag interface: allocates monotonically increasing speculation IDs to new branches and drives new_spec_id/new_spec_valid.
- Tracks which IDs are outstanding, retires them on correct resolution, and on a mispredict broadcasts invalid/miss_id.
- Sits in the front-end next to branch issue; every speculation-tag consumer (tag registers, shadow state) reads its outputs.

---
 rtl/spec_tag_mgr.sv | 110 +++++++++++
 tb/tb_spec_tag_mgr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spec_tag_mgr.sv
// Speculation-tag manager: allocates monotonically increasing speculation IDs,
// tracks live IDs, retires them on correct resolve and broadcasts squashes.
// Optional resolve checker enabled by defining SPEC_TAG_RESOLVE_CHECK_EN.
module spec_tag_mgr #(
  parameter int unsigned ID_W    = 5,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  output logic            alloc_gnt,
  output logic [ID_W-1:0] new_spec_id,
  output logic            new_spec_valid,
  input  logic            resolve_valid,
  input  logic [ID_W-1:0] resolve_id,
  input  logic            resolve_miss,
  output logic            invalid,
  output logic [ID_W-1:0] miss_id,
  output logic [ID_W:0]   outstanding,
  output logic            full,
  output logic            resolve_err
);

  localparam int unsigned N = 1 << ID_W;

  typedef enum logic [1:0] {RUN, SQUASH, WRAP_WAIT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] next_id, next_id_nxt;
  logic [N-1:0]    live, live_nxt;
  logic [ID_W:0]   cnt;
  logic            hit, do_miss, do_ok;

  assign hit     = live[resolve_id];
  assign do_miss = resolve_valid & resolve_miss & hit;
  assign do_ok   = resolve_valid & ~resolve_miss & hit;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) cnt = cnt + (ID_W+1)'(live[i]);
  end

  assign outstanding = cnt;
  assign full        = (cnt == (ID_W+1)'(MAX_OUT));
  // Any mispredict request blocks allocation, even one that later proves non-live.
  assign alloc_gnt   = alloc_req & (state == RUN) & ~full & ~(resolve_valid & resolve_miss);

  always_comb begin
    state_nxt   = state;
    next_id_nxt = next_id;
    live_nxt    = live;
    if (do_ok) live_nxt[resolve_id] = 1'b0;
    if (do_miss) begin
      for (int unsigned k = 0; k < N; k++)
        if (k >= 32'(resolve_id)) live_nxt[k] = 1'b0;
      next_id_nxt = resolve_id;
      state_nxt   = SQUASH;
    end else begin
      unique case (state)
        RUN: begin
          if (alloc_gnt) begin
            live_nxt[next_id] = 1'b1;
            next_id_nxt       = next_id + ID_W'(1);
            if (&next_id) state_nxt = WRAP_WAIT;
          end
        end
        SQUASH: state_nxt = RUN;
        WRAP_WAIT: begin
          if (live == '0) begin
            next_id_nxt = '0;
            state_nxt   = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      next_id        <= '0;
      live           <= '0;
      new_spec_valid <= 1'b0;
      new_spec_id    <= '0;
      invalid        <= 1'b0;
      miss_id        <= '0;
    end else begin
      state          <= state_nxt;
      next_id        <= next_id_nxt;
      live           <= live_nxt;
      new_spec_valid <= alloc_gnt;
      if (alloc_gnt) new_spec_id <= next_id;
      invalid        <= do_miss;
      if (do_miss) miss_id <= resolve_id;
    end
  end

`ifdef SPEC_TAG_RESOLVE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((resolve_valid & ~hit) | (resolve_miss & ~resolve_valid)) err_q <= 1'b1;
  end
  assign resolve_err = err_q;
`else
  assign resolve_err = 1'b0;
`endif

endmodule

// File: tb/tb_spec_tag_mgr.sv
// Self-checking bench for spec_tag_mgr: queue-based reference model checked every
// cycle on the falling edge, plus directed literal pins on key scenarios.
module tb_spec_tag_mgr;

  localparam int unsigned ID_W    = 5;
  localparam int unsigned MAX_OUT = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_req = 1'b0;
  logic            alloc_gnt;
  logic [ID_W-1:0] new_spec_id;
  logic            new_spec_valid;
  logic            resolve_valid = 1'b0;
  logic [ID_W-1:0] resolve_id = '0;
  logic            resolve_miss = 1'b0;
  logic            invalid;
  logic [ID_W-1:0] miss_id;
  logic [ID_W:0]   outstanding;
  logic            full;
  logic            resolve_err;

  spec_tag_mgr #(.ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .new_spec_id(new_spec_id), .new_spec_valid(new_spec_valid),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_miss(resolve_miss),
    .invalid(invalid), .miss_id(miss_id),
    .outstanding(outstanding), .full(full), .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of live IDs, next ID counter, and two mode flags.
  int live_q[$];
  int m_next = 0;
  bit m_wrap = 0, m_sq = 0, chk_en = 0;
  bit e_nsv = 0, e_inv = 0, e_err = 0;
  int e_nsid = 0, e_mid = 0;

  function automatic bit m_is_live(int id);
    foreach (live_q[j]) if (live_q[j] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_gnt();
    return alloc_req && !m_sq && !m_wrap && (live_q.size() < MAX_OUT)
           && !(resolve_valid && resolve_miss);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live_q.delete();
      m_next = 0; m_wrap = 0; m_sq = 0;
      e_nsv = 0; e_nsid = 0; e_inv = 0; e_mid = 0; e_err = 0;
      chk_en = 1;
    end else begin
      bit g, lv, mis, cor, empty0;
      int id;
      int keep[$];
      g      = m_gnt();
      id     = int'(resolve_id);
      lv     = m_is_live(id);
      mis    = resolve_valid && resolve_miss && lv;
      cor    = resolve_valid && !resolve_miss && lv;
      empty0 = (live_q.size() == 0);
      e_nsv  = g;
      if (g) e_nsid = m_next;
      e_inv = mis;
      if (mis) e_mid = id;
`ifdef SPEC_TAG_RESOLVE_CHECK_EN
      if ((resolve_valid && !lv) || (resolve_miss && !resolve_valid)) e_err = 1;
`endif
      keep.delete();
      foreach (live_q[j])
        if (!(cor && live_q[j] == id) && !(mis && live_q[j] >= id)) keep.push_back(live_q[j]);
      if (g) keep.push_back(m_next);
      live_q = keep;
      if (mis) begin
        m_next = id; m_sq = 1; m_wrap = 0;
      end else begin
        m_sq = 0;
        if (m_wrap && empty0) begin
          m_wrap = 0; m_next = 0;
        end else if (g) begin
          m_wrap = (m_next == (1 << ID_W) - 1);
          m_next = (m_next + 1) % (1 << ID_W);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alloc_gnt", alloc_gnt, m_gnt());
      chk("new_spec_valid", new_spec_valid, e_nsv);
      if (e_nsv) chk("new_spec_id", new_spec_id, e_nsid);
      chk("invalid", invalid, e_inv);
      if (e_inv) chk("miss_id", miss_id, e_mid);
      chk("outstanding", outstanding, live_q.size());
      chk("full", full, live_q.size() == MAX_OUT);
      chk("resolve_err", resolve_err, e_err);
    end
  end

  task automatic step(input bit r, input bit req, input bit rv, input int rid, input bit rm);
    @(posedge clk); #2;
    rst = r; alloc_req = req; resolve_valid = rv; resolve_id = ID_W'(rid); resolve_miss = rm;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_err;
`ifdef SPEC_TAG_RESOLVE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Three back-to-back allocations.
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_rst_outstanding", outstanding, 0);
    chk("pin_s1_gnt0", alloc_gnt, 1);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_s1_id0", {new_spec_valid, new_spec_id}, {1'b1, 5'd0});
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_s1_id2", {new_spec_valid, new_spec_id}, {1'b1, 5'd2});
    chk("pin_s1_out3", outstanding, 3);

    // Fill to MAX_OUT, then resolve-with-request against the pre-resolve count.
    for (int i = 3; i < 8; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_s2_full", full, 1);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_s2_gnt_full", alloc_gnt, 0);
    step(0, 1, 1, 3, 0); @(negedge clk);
    chk("pin_s2_gnt_resolve", alloc_gnt, 0);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_s2_gnt_after", alloc_gnt, 1);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_s2_id8", new_spec_id, 8);
    chk("pin_s2_out8", outstanding, 8);

    // Mispredict of ID 2 with IDs 0..5 live.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 2, 1);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_s3_inv", {invalid, miss_id}, {1'b1, 5'd2});
    chk("pin_s3_out2", outstanding, 2);
    chk("pin_s3_gnt_sq", alloc_gnt, 0);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_s3_gnt", alloc_gnt, 1);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_s3_id2", new_spec_id, 2);

    // Allocation request colliding with a mispredict of ID 1.
    step(0, 1, 1, 1, 1); @(negedge clk);
    chk("pin_s4_gnt", alloc_gnt, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_s4_nsv", new_spec_valid, 0);
    chk("pin_s4_inv", {invalid, miss_id}, {1'b1, 5'd1});

    // Reset on a granting cycle drops the pending pulse.
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_rst_nsv", new_spec_valid, 0);

    // Back-to-back squashes.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 3, 1);
    step(0, 0, 1, 1, 1); @(negedge clk);
    chk("pin_b2b_inv1", {invalid, miss_id}, {1'b1, 5'd3});
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_b2b_inv2", {invalid, miss_id}, {1'b1, 5'd1});
    step(0, 0, 0, 0, 0);

    // Walk the whole ID space with trailing correct resolves, then wrap.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, (i > 0), i - 1, 0);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_w_gnt_live", alloc_gnt, 0);
    chk("pin_w_id31", new_spec_id, 31);
    step(0, 1, 1, 31, 0);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_w_gnt_drain", alloc_gnt, 0);
    step(0, 1, 0, 0, 0); @(negedge clk);
    chk("pin_w_gnt_run", alloc_gnt, 1);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_w_id0", {new_spec_valid, new_spec_id}, {1'b1, 5'd0});

    // Resolves against non-live IDs, plus a stray miss flag.
    step(0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_e_out", outstanding, 1);
    chk("pin_e_err", resolve_err, exp_err);
    step(0, 1, 1, 9, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_e_inv", invalid, 0);
    chk("pin_e_err_sticky", resolve_err, exp_err);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); @(negedge clk);
    chk("pin_e_err_rst", resolve_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
